// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and limits for the memory-port round-robin arbiter family.
package mem_arb_pkg;

  // Upper bound on requester ports a single arbiter instance can serve.
  localparam int MEM_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  // Width of a port index; a one-port ring still needs a 1-bit pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and lower-memory-side bus of the round-robin arbiter.
// slave is the arbiter's view; master is the requesters + RAM view.
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0][BE_W-1:0]   req_data_en;
  logic [NUM_REQ-1:0]             req_read_en;
  logic [NUM_REQ-1:0]             req_write_en;
  logic [DATA_W-1:0]              req_data_o;
  logic [NUM_REQ-1:0]             req_done;

  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_data_i;
  logic [BE_W-1:0]                mem_data_en;
  logic                           mem_read_en;
  logic                           mem_write_en;
  logic [DATA_W-1:0]              mem_data_o;
  logic                           mem_done;

  modport slave (
    input  req_addr, req_data_i, req_data_en, req_read_en, req_write_en,
    input  mem_data_o, mem_done,
    output req_data_o, req_done,
    output mem_addr, mem_data_i, mem_data_en, mem_read_en, mem_write_en
  );

  modport master (
    output req_addr, req_data_i, req_data_en, req_read_en, req_write_en,
    output mem_data_o, mem_done,
    input  req_data_o, req_done,
    input  mem_addr, mem_data_i, mem_data_en, mem_read_en, mem_write_en
  );

endinterface

// File: rtl/mem_rr_arbiter_picker.sv
// Rotating-priority picker: first set bit of req scanning rr_ptr, rr_ptr+1, ...
// wrapping at NUM_REQ. Purely combinational so other ring arbiters can reuse it.
module rr_priority_picker #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   grant_idx
);

  // Scan from the farthest offset down so the nearest active index wins last.
  // Wrap is an explicit compare so non-power-of-two NUM_REQ works.
  always_comb begin
    logic [PTR_W:0] k;
    grant_valid = 1'b0;
    grant_idx   = '0;
    k           = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (k >= (PTR_W+1)'(NUM_REQ)) k = k - (PTR_W+1)'(NUM_REQ);
      if (req[k[PTR_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = k[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one lower memory port among NUM_REQ requesters.
// One transaction outstanding at a time: IDLE grants, ISSUE waits for mem_done,
// RESP pulses req_done for one cycle so the winner can drop its request.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  mem_rr_arbiter_if.slave bus
);

  localparam int PTR_W = idx_w(NUM_REQ);
  localparam int BE_W  = DATA_W / 8;

  arb_state_t          state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  active;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;

  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [NUM_REQ-1:0]  done_q;

  assign active = bus.req_read_en | bus.req_write_en;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req         (active),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_vld),
    .grant_idx   (pick_idx)
  );

  // Arbitration FSM with registered lower-port and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rdata_q     <= '0;
      done_q      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            grant_idx   <= pick_idx;
            mem_addr_q  <= bus.req_addr[pick_idx];
            mem_wdata_q <= bus.req_data_i[pick_idx];
            mem_be_q    <= bus.req_data_en[pick_idx];
            // write wins if a port ever shows both levels
            mem_wr_q    <= bus.req_write_en[pick_idx];
            mem_rd_q    <= ~bus.req_write_en[pick_idx];
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (bus.mem_done) begin
            if (mem_rd_q) rdata_q <= bus.mem_data_o;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            done_q   <= NUM_REQ'(1) << grant_idx;
            rr_ptr   <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state    <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          done_q <= '0;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_i   = mem_wdata_q;
  assign bus.mem_data_en  = mem_be_q;
  assign bus.mem_read_en  = mem_rd_q;
  assign bus.mem_write_en = mem_wr_q;
  assign bus.req_data_o   = rdata_q;
  assign bus.req_done     = done_q;

  // Spurious completions from the lower port outside ISSUE are ignored; track them.
  c_stray_mem_done: cover property (@(posedge clk) disable iff (reset)
    bus.mem_done && (state != ARB_ISSUE));

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed + randomized bench for mem_rr_arbiter with a transaction-level model.
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // RAM model state (lower port) and requester-level reference state
  bit          mem_auto;
  int          mem_lat;
  logic [31:0] ram     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] r_addr [NR];
  logic [31:0] r_data [NR];
  logic [3:0]  r_be   [NR];
  bit          r_wr   [NR];
  logic [31:0] last_read;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // first pending port scanning ptr, ptr+1, ... mod NR; -1 if none
  function automatic int pick(input bit p[NR], input int ptr);
    for (int k = 0; k < NR; k++) if (p[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v == (NR'(1) << i)) return i;
    return 99;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    bus.req_addr[p] = a; bus.req_data_i[p] = d; bus.req_data_en[p] = be;
    bus.req_write_en[p] = wr; bus.req_read_en[p] = rd;
    r_addr[p] = a; r_data[p] = d; r_be[p] = be; r_wr[p] = wr;
  endtask

  task automatic clr_req(input int p);
    bus.req_write_en[p] = 1'b0; bus.req_read_en[p] = 1'b0;
  endtask

  // Lower-port RAM: mem_done after mem_lat cycles of a held request.
  initial begin
    int rcnt;
    logic [31:0] a;
    rcnt = 0;
    bus.mem_done = 1'b0;
    bus.mem_data_o = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        if (bus.mem_read_en || bus.mem_write_en) begin
          rcnt++;
          a = bus.mem_addr;
          if (rcnt == mem_lat) begin
            bus.mem_done = 1'b1;
            if (bus.mem_write_en) begin
              ram[a] = merge(ram.exists(a) ? ram[a] : dflt(a), bus.mem_data_i, bus.mem_data_en);
              bus.mem_data_o = $urandom;
            end else begin
              bus.mem_data_o = ram.exists(a) ? ram[a] : dflt(a);
            end
          end else begin
            bus.mem_done = 1'b0;
            bus.mem_data_o = $urandom;
          end
        end else begin
          rcnt = 0;
          bus.mem_done = 1'b0;
          bus.mem_data_o = $urandom;
        end
      end
    end
  end

  // results of one directed transaction
  int          t_en, t_first, t_ndone, t_done_tick;
  logic [1:0]  t_vec;
  logic [31:0] t_data, t_addr, t_wd;
  logic [3:0]  t_be;
  logic        t_wr, t_rd;

  task automatic txn(input int p, input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input int lat);
    mem_lat = lat;
    set_req(p, wr, rd, a, d, be);
    t_en = 0; t_first = -1; t_ndone = 0; t_done_tick = -1; t_vec = '0; t_data = '0;
    t_addr = '0; t_wd = '0; t_be = '0; t_wr = 1'b0; t_rd = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.mem_read_en || bus.mem_write_en) begin
        t_en++;
        if (t_first < 0) begin
          t_first = c; t_addr = bus.mem_addr; t_wd = bus.mem_data_i; t_be = bus.mem_data_en;
          t_wr = bus.mem_write_en; t_rd = bus.mem_read_en;
        end
      end
      if (bus.req_done != '0) begin
        t_ndone++; t_vec = bus.req_done; t_data = bus.req_data_o; t_done_tick = c;
        clr_req(p);
      end
    end
  endtask

  initial begin
    int order[$];
    int cnt[NR];
    int idx, first_done, total, g, exp_g, m_ptr, done_cnt, just;
    bit pend[NR];
    bit prev_pend[NR];
    bit prev_en, en, any_bad;

    mem_auto = 1'b1; mem_lat = 1; reset = 1'b1; last_read = '0;
    bus.req_addr = '0; bus.req_data_i = '0; bus.req_data_en = '0;
    bus.req_read_en = '0; bus.req_write_en = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    chk("rst_req_done", bus.req_done, 0);
    chk("rst_req_data_o", bus.req_data_o, 0);
    chk("rst_mem_en", {bus.mem_read_en, bus.mem_write_en}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    tick();

    // 1: single read, 3-cycle RAM
    ram[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
    txn(0, 1'b0, 1'b1, 32'h100, '0, 4'hF, 3);
    chk("t1_en_latency", t_first, 1);
    chk("t1_read_en_cycles", t_en, 3);
    chk("t1_addr", t_addr, 32'h100);
    chk("t1_done_count", t_ndone, 1);
    chk("t1_done_vec", t_vec, 2'b01);
    chk("t1_done_tick", t_done_tick, 4);
    chk("t1_rdata", t_data, 32'hDEAD_BEEF);
    last_read = 32'hDEAD_BEEF;

    // 2: tie from reset, then back-to-back port0
    reset = 1'b1; tick(); reset = 1'b0; last_read = '0;
    chk("t2_rdata_after_rst", bus.req_data_o, 0);
    mem_lat = 1;
    set_req(0, 1'b0, 1'b1, 32'h10, '0, 4'hF);
    set_req(1, 1'b0, 1'b1, 32'h14, '0, 4'hF);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.req_done != '0) begin
        idx = onehot_idx(bus.req_done);
        order.push_back(idx);
        if (idx < NR) begin
          chk("t2_rdata", bus.req_data_o, ref_rd(r_addr[idx]));
          last_read = ref_rd(r_addr[idx]);
          clr_req(idx);
          if (idx == 0 && order.size() == 1) set_req(0, 1'b0, 1'b1, 32'h18, '0, 4'hF);
        end
      end
    end
    chk("t2_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("t2_first", order[0], 0);
      chk("t2_second", order[1], 1);
      chk("t2_third", order[2], 0);
    end

    // 3: masked write from port1 (both levels raised: write must win)
    txn(1, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011, 2);
    chk("t3_write_en", t_wr, 1);
    chk("t3_read_en", t_rd, 0);
    chk("t3_addr", t_addr, 32'h2000);
    chk("t3_be", t_be, 4'b0011);
    chk("t3_wdata", t_wd, 32'h1234_5678);
    chk("t3_done_vec", t_vec, 2'b10);
    chk("t3_rdata_kept", t_data, last_read);
    ref_mem[32'h2000] = merge(ref_rd(32'h2000), 32'h1234_5678, 4'b0011);

    // 4: zero-wait RAM, both ports saturating, 100 transactions
    mem_lat = 1; cnt[0] = 0; cnt[1] = 0; total = 0; first_done = -1;
    set_req(0, 1'b0, 1'b1, 32'h2000, '0, 4'hF);
    set_req(1, 1'b0, 1'b1, 32'h100, '0, 4'hF);
    for (int c = 1; c <= 1000 && total < 100; c++) begin
      tick();
      if (bus.req_done != '0) begin
        idx = onehot_idx(bus.req_done);
        if (first_done < 0) first_done = c;
        if (idx < NR) begin
          cnt[idx]++;
          if (total < 4) chk("t4_rdata", bus.req_data_o, ref_rd(r_addr[idx]));
          set_req(idx, 1'b0, 1'b1, r_addr[idx], '0, 4'hF);
        end
        total++;
      end
    end
    clr_req(0); clr_req(1);
    chk("t4_first_done_tick", first_done, 2);
    chk("t4_total", total, 100);
    chk("t4_port0_count", cnt[0], 50);
    chk("t4_port1_count", cnt[1], 50);
    repeat (4) tick();

    // 5: reset during ISSUE, stray mem_done two cycles later
    mem_auto = 1'b0; bus.mem_done = 1'b0;
    set_req(1, 1'b0, 1'b1, 32'h300, '0, 4'hF);
    tick();
    chk("t5_in_issue", bus.mem_read_en, 1);
    reset = 1'b1; clr_req(1);
    tick();
    reset = 1'b0;
    chk("t5_rst_mem_en", {bus.mem_read_en, bus.mem_write_en}, 0);
    chk("t5_rst_done", bus.req_done, 0);
    chk("t5_rst_rdata", bus.req_data_o, 0);
    chk("t5_rst_addr", bus.mem_addr, 0);
    any_bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.mem_done = (c == 0);
      bus.mem_data_o = 32'hBAD0_BAD0;
      if (bus.req_done != '0 || bus.mem_read_en || bus.mem_write_en) any_bad = 1'b1;
    end
    bus.mem_done = 1'b0;
    chk("t5_no_activity", any_bad, 0);
    chk("t5_rdata_zero", bus.req_data_o, 0);
    chk("t5_state_idle", dut.state, ARB_IDLE);
    chk("t5_rr_ptr_zero", dut.rr_ptr, 0);
    mem_auto = 1'b1;
    last_read = '0;

    // 6: port0 drops its request during ISSUE; port1 waits
    mem_lat = 3;
    set_req(0, 1'b0, 1'b1, 32'h40, '0, 4'hF);
    set_req(1, 1'b0, 1'b1, 32'h44, '0, 4'hF);
    tick();
    chk("t6_grant0_addr", bus.mem_addr, 32'h40);
    clr_req(0);
    idx = 99;
    for (int c = 0; c < 20 && idx == 99; c++) begin
      tick();
      if (bus.req_done != '0) idx = onehot_idx(bus.req_done);
    end
    chk("t6_done_port0", idx, 0);
    last_read = ref_rd(32'h40);
    tick();
    chk("t6_idle_after_resp", bus.mem_read_en, 0);
    tick();
    chk("t6_grant1_en", bus.mem_read_en, 1);
    chk("t6_grant1_addr", bus.mem_addr, 32'h44);
    idx = 99;
    for (int c = 0; c < 20 && idx == 99; c++) begin
      tick();
      if (bus.req_done != '0) idx = onehot_idx(bus.req_done);
    end
    chk("t6_done_port1", idx, 1);
    clr_req(1);

    // Random traffic against the transaction-level model
    reset = 1'b1; tick(); reset = 1'b0;
    m_ptr = 0; last_read = '0; exp_g = -1; done_cnt = 0; prev_en = 1'b0;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; prev_pend[i] = 1'b0; end
    for (int c = 0; c < 3000 && done_cnt < 60; c++) begin
      tick();
      just = -1;
      en = bus.mem_read_en | bus.mem_write_en;
      if (en && !prev_en) begin
        g = pick(prev_pend, m_ptr);
        chk("rnd_grant_valid", g >= 0, 1);
        if (g >= 0) begin
          chk("rnd_grant_addr", bus.mem_addr, r_addr[g]);
          chk("rnd_grant_op", {bus.mem_write_en, bus.mem_read_en}, r_wr[g] ? 2'b10 : 2'b01);
          if (r_wr[g]) chk("rnd_grant_wdata", {bus.mem_data_en, bus.mem_data_i}, {r_be[g], r_data[g]});
          m_ptr = (g + 1) % NR;
        end
        exp_g = g;
      end
      if (bus.req_done != '0) begin
        chk("rnd_done_vec", bus.req_done, (exp_g >= 0) ? (NR'(1) << exp_g) : '0);
        if (exp_g >= 0) begin
          if (r_wr[exp_g]) ref_mem[r_addr[exp_g]] = merge(ref_rd(r_addr[exp_g]), r_data[exp_g], r_be[exp_g]);
          else last_read = ref_rd(r_addr[exp_g]);
          chk("rnd_rdata", bus.req_data_o, last_read);
          pend[exp_g] = 1'b0; clr_req(exp_g); just = exp_g;
        end
        exp_g = -1; done_cnt++;
        mem_lat = $urandom_range(1, 4);
      end
      for (int p = 0; p < NR; p++) begin
        if (!pend[p] && p != just && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1)
            set_req(p, 1'b1, 1'b0, 32'h800 + 4 * $urandom_range(0, 7), $urandom, 4'($urandom_range(1, 15)));
          else
            set_req(p, 1'b0, 1'b1, 32'h800 + 4 * $urandom_range(0, 7), '0, 4'hF);
          pend[p] = 1'b1;
        end
      end
      prev_pend = pend;
      prev_en = en;
    end
    chk("rnd_completed", done_cnt, 60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
